seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_defs.sv | 33 +++
 rtl/seg7_decode.sv | 33 +++
 rtl/seg_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_defs.sv
// ============================================================================
// seg_defs : shared segment constants and FSM state encoding for seg_scan_ctrl
// Revision : 1.0
// ============================================================================
`default_nettype none

package seg_defs;

  // Active-low, bit order g..a
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;

  typedef enum logic [0:0] {
    ST_DISP = 1'b0,
    ST_GAP  = 1'b1
  } scan_state_t;

  function automatic logic [3:0] dig_sel_n(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// seg7_decode : BCD nibble to active-low 7-segment pattern, blank above 9
// Revision    : 1.0
// ============================================================================
`default_nettype none

module seg7_decode
  import seg_defs::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// seg_scan_ctrl : 4-digit multiplexed 7-segment scanner with frame-atomic
//                 display updates. Optional leading-zero blanking is enabled
//                 by defining SEG_LZ_BLANK_EN.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module seg_scan_ctrl
  import seg_defs::*;
#(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned GAP      = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd_req,
  input  logic [15:0] digits_in,
  output logic [6:0]  seg,
  output logic [3:0]  dig_en_n,
  output logic        upd_ack,
  output logic        frame_done
);

  localparam int unsigned          CNT_W    = $clog2((PRESCALE > GAP) ? PRESCALE : GAP);
  localparam logic [CNT_W-1:0]     PRE_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0]     GAP_LAST = CNT_W'(GAP - 1);

  scan_state_t       state;
  logic [1:0]        idx;
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       disp;
  logic [15:0]       pend;
  logic              pend_v;

  logic              disp_end;
  logic              gap_end;
  logic              wrap;
  logic [3:0]        lz_mask;
  logic [3:0]        cur_nib;
  logic [3:0]        dec_in;
  logic [6:0]        dec_seg;

  assign disp_end = (state == ST_DISP) && (cnt == PRE_LAST);
  assign gap_end  = (state == ST_GAP)  && (cnt == GAP_LAST);
  assign wrap     = gap_end && (idx == 2'd3);

`ifdef SEG_LZ_BLANK_EN
  // A digit is a leading zero only if every digit above it is one too
  assign lz_mask[3] = (disp[15:12] == 4'd0);
  assign lz_mask[2] = lz_mask[3] && (disp[11:8] == 4'd0);
  assign lz_mask[1] = lz_mask[2] && (disp[7:4]  == 4'd0);
  assign lz_mask[0] = 1'b0;
`else
  assign lz_mask = 4'b0000;
`endif

  assign cur_nib = disp[{idx, 2'b00} +: 4];
  assign dec_in  = lz_mask[idx] ? 4'hF : cur_nib;

  seg7_decode u_dec (
    .nibble (dec_in),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_DISP;
      idx        <= 2'd0;
      cnt        <= '0;
      disp       <= 16'hFFFF;
      pend       <= 16'h0000;
      pend_v     <= 1'b0;
      seg        <= SEG_BLANK;
      dig_en_n   <= 4'hF;
      upd_ack    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      upd_ack    <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        ST_DISP: begin
          if (disp_end) begin
            state <= ST_GAP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_end) begin
            state <= ST_DISP;
            cnt   <= '0;
            idx   <= idx + 2'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_DISP;
      endcase

      // The old pending value is consumed at the wrap; a request on the same
      // edge becomes the next pending value and waits for the following wrap.
      if (wrap) begin
        frame_done <= 1'b1;
        if (pend_v) begin
          disp    <= pend;
          upd_ack <= 1'b1;
        end
      end

      if (upd_req) begin
        pend   <= digits_in;
        pend_v <= 1'b1;
      end else if (wrap) begin
        pend_v <= 1'b0;
      end

      if (state == ST_DISP) begin
        dig_en_n <= dig_sel_n(idx);
        seg      <= dec_seg;
      end else begin
        dig_en_n <= 4'hF;
        seg      <= SEG_BLANK;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
// tb_seg_scan_ctrl : self-checking bench for seg_scan_ctrl (PRESCALE=4, GAP=2)
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

  localparam int P     = 4;
  localparam int G     = 2;
  localparam int PER   = P + G;
  localparam int FRAME = 4 * PER;

`ifdef SEG_LZ_BLANK_EN
  localparam logic [6:0] LZ0 = 7'h7F;
`else
  localparam logic [6:0] LZ0 = 7'h40;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        upd_req = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic [6:0]  seg;
  logic [3:0]  dig_en_n;
  logic        upd_ack;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.PRESCALE(P), .GAP(G)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd_req    (upd_req),
    .digits_in  (digits_in),
    .seg        (seg),
    .dig_en_n   (dig_en_n),
    .upd_ack    (upd_ack),
    .frame_done (frame_done)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: absolute cycle count since reset plus pending/displayed values
  int          k;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_pv;
  logic [6:0]  seg_tab [16];

  logic [6:0]  cap_seg [4];
  int          cap_cnt [4];
  int          cap_off;
  int          cap_acks;

  typedef struct {
    logic [15:0] val;
    logic [6:0]  e0, e1, e2, e3;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_digit(input logic [15:0] v, input int d);
    logic [3:0] nib;
    nib = v[4*d +: 4];
`ifdef SEG_LZ_BLANK_EN
    begin
      bit lead_zero;
      lead_zero = 1'b1;
      for (int j = d + 1; j < 4; j++)
        if (v[4*j +: 4] != 4'd0) lead_zero = 1'b0;
      if (d > 0 && lead_zero && nib == 4'd0) return 7'h7F;
    end
`endif
    return seg_tab[nib];
  endfunction

  task automatic step(input bit req, input logic [15:0] d);
    logic [15:0] old_disp;
    int          pos, dig;
    bit          on, wrap, e_ack;
    logic [3:0]  e_den;
    logic [6:0]  e_seg;
    upd_req   = req;
    digits_in = d;
    @(posedge clk);
    old_disp = m_disp;
    pos      = k % FRAME;
    k++;
    wrap  = (k % FRAME) == 0;
    e_ack = wrap && m_pv;
    if (e_ack) begin
      m_disp = m_pend;
      m_pv   = 1'b0;
    end
    if (req) begin
      m_pend = d;
      m_pv   = 1'b1;
    end
    on    = (pos % PER) < P;
    dig   = pos / PER;
    e_den = on ? ~(4'b0001 << dig) : 4'hF;
    e_seg = on ? ref_digit(old_disp, dig) : 7'h7F;
    @(negedge clk);
    upd_req = 1'b0;
    check("dig_en_n", 32'(dig_en_n), 32'(e_den));
    check("seg", 32'(seg), 32'(e_seg));
    check("upd_ack", 32'(upd_ack), 32'(e_ack));
    check("frame_done", 32'(frame_done), 32'(wrap));
  endtask

  task automatic do_reset(input int n);
    rst_n   = 1'b0;
    upd_req = 1'b0;
    k       = 0;
    m_pv    = 1'b0;
    m_disp  = 16'hFFFF;
    #1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_dig", 32'(dig_en_n), 32'hF);
      check("rst_ack", 32'(upd_ack), 32'h0);
      check("rst_fd", 32'(frame_done), 32'h0);
    end
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step(1'b0, 16'h0);
      if (upd_ack) found = 1'b1;
    end
    check(name, 32'(found), 32'h1);
  endtask

  // Runs one full frame right after a wrap, recording what each digit showed
  task automatic capture_frame();
    logic [3:0] msk;
    for (int i = 0; i < 4; i++) begin
      cap_seg[i] = 7'h7F;
      cap_cnt[i] = 0;
    end
    cap_off  = 0;
    cap_acks = 0;
    for (int c = 0; c < FRAME; c++) begin
      step(1'b0, 16'h0);
      if (upd_ack) cap_acks++;
      if (dig_en_n == 4'hF) cap_off++;
      for (int i = 0; i < 4; i++) begin
        msk = ~(4'b0001 << i);
        if (dig_en_n == msk) begin
          cap_seg[i] = seg;
          cap_cnt[i]++;
        end
      end
    end
  endtask

  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h18;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'h7F;

    vecs[0] = '{16'h1234, 7'h19, 7'h30, 7'h24, 7'h79};
    vecs[1] = '{16'h9876, 7'h02, 7'h78, 7'h00, 7'h18};
    vecs[2] = '{16'h00A5, 7'h12, 7'h7F, LZ0,   LZ0};
    vecs[3] = '{16'h0F00, 7'h40, 7'h40, 7'h7F, LZ0};

    // Reset and first enabled digit one clock after release
    @(negedge clk);
    do_reset(3);
    step(1'b0, 16'h0);
    check("first_dig_en", 32'(dig_en_n), 32'hE);
    check("first_seg_blank", 32'(seg), 32'h7F);
    for (int i = 0; i < FRAME; i++) step(1'b0, 16'h0);

    // Directed decode vectors
    for (int v = 0; v < 4; v++) begin
      step(1'b1, vecs[v].val);
      wait_ack("vec_ack");
      capture_frame();
      check("vec_d0", 32'(cap_seg[0]), 32'(vecs[v].e0));
      check("vec_d1", 32'(cap_seg[1]), 32'(vecs[v].e1));
      check("vec_d2", 32'(cap_seg[2]), 32'(vecs[v].e2));
      check("vec_d3", 32'(cap_seg[3]), 32'(vecs[v].e3));
      for (int i = 0; i < 4; i++) check("vec_on_len", 32'(cap_cnt[i]), 32'(P));
      check("vec_off_len", 32'(cap_off), 32'(4 * G));
    end

    // Last request within a frame wins, with a single acknowledge
    step(1'b1, 16'h1111);
    step(1'b0, 16'h0);
    step(1'b1, 16'h5678);
    wait_ack("lw_ack");
    capture_frame();
    check("lw_acks_after", 32'(cap_acks), 32'h0);
    check("lw_d0", 32'(cap_seg[0]), 32'h00);
    check("lw_d3", 32'(cap_seg[3]), 32'h12);

    // Request on the wrap edge while another value is pending
    step(1'b1, 16'h2222);
    while (((k + 1) % FRAME) != 0) step(1'b0, 16'h0);
    step(1'b1, 16'h9999);
    check("wc_ack1", 32'(upd_ack), 32'h1);
    capture_frame();
    check("wc_d0_2222", 32'(cap_seg[0]), 32'h24);
    check("wc_ack2", 32'(upd_ack), 32'h1);
    capture_frame();
    check("wc_d0_9999", 32'(cap_seg[0]), 32'h18);

    // Reset mid-frame drops the pending update
    step(1'b1, 16'h4321);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0);
    do_reset(3);
    begin
      int bad_ack, bad_seg;
      bad_ack = 0;
      bad_seg = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
        step(1'b0, 16'h0);
        if (upd_ack) bad_ack++;
        if (seg != 7'h7F) bad_seg++;
      end
      check("mr_no_ack", 32'(bad_ack), 32'h0);
      check("mr_blank", 32'(bad_seg), 32'h0);
    end
    step(1'b1, 16'h0007);
    wait_ack("mr_new_ack");
    capture_frame();
    check("mr_new_d0", 32'(cap_seg[0]), 32'h78);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) == 0, 16'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
